cram_seq: RTL and testbench

//  Bit-serial macro-op sequencer and port arbiter for the CRam compute array.

---
 rtl/cram_seq.sv | 215 +++++++++++++++++++++
 tb/tb_cram_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_seq.sv
// Bit-serial macro-op sequencer for the CRam compute array: expands vector
// commands into one micro-instruction per cycle and shares the array with the host port.
module cram_seq #(
  parameter int MAX_WIDTH = 32,
  parameter int TMP_COL   = 255,
  parameter int WW        = $clog2(MAX_WIDTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [2:0]    cmd_op_i,
  input  logic [WW-1:0] cmd_width_i,
  input  logic [7:0]    cmd_a_i,
  input  logic [7:0]    cmd_b_i,
  input  logic [7:0]    cmd_d_i,
  input  logic          cmd_tag_i,
  input  logic          cmd_cout_i,
  output logic [31:0]   inst_o,
  input  logic          mem_req_i,
  output logic          mem_gnt_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  // state | meaning
  // IDLE  | waiting for a command or a host request
  // ISSUE | one micro-op per cycle on inst_o
  // DRAIN | NOP cycle; ends a command or empties the array before a host grant
  // HOST  | array handed to the host port while mem_req_i is held
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOST} state_t;
  typedef enum logic [1:0] {PH_PRE, PH_BIT, PH_STC, PH_END} phase_t;

  typedef struct packed {
    logic [2:0]    op;
    logic [WW-1:0] width;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [7:0]    d;
    logic          tag;
    logic          cout;
  } cmd_t;

  // Position of the next micro-op to issue; half selects INV/ADD within a SUB bit.
  typedef struct packed {
    phase_t        ph;
    logic [WW-1:0] idx;
    logic          half;
  } pos_t;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_CPY = 3'd2,
                         OP_AND = 3'd3, OP_OR  = 3'd4, OP_XOR = 3'd5;
  localparam logic [3:0] U_CPY = 4'h1, U_AND = 4'h2, U_OR = 4'h3, U_XOR = 4'h4,
                         U_ADD = 4'h6, U_INV = 4'h8, U_STC = 4'hB, U_SC = 4'hD,
                         U_CC  = 4'hE;
  localparam logic [7:0] TMP = 8'(TMP_COL);

  function automatic logic [31:0] micro(input cmd_t c, input pos_t p);
    logic [7:0] ca, cb, cd;
    logic [3:0] en_w;
    ca   = c.a + 8'(p.idx);
    cb   = c.b + 8'(p.idx);
    cd   = c.d + 8'(p.idx);
    en_w = {1'b1, 2'b00, c.tag};
    micro = 32'h0;
    case (p.ph)
      PH_PRE: micro = {4'h8, (c.op == OP_SUB) ? U_SC : U_CC, 24'h0};
      PH_STC: micro = {en_w, U_STC, 16'h0, c.d + 8'(c.width)};
      PH_BIT: begin
        case (c.op)
          OP_ADD: micro = {en_w, U_ADD, ca, cb, cd};
          OP_SUB: micro = p.half ? {en_w, U_ADD, ca, TMP, cd}
                                 : {en_w, U_INV, cb, 8'h00, TMP};
          OP_CPY: micro = {en_w, U_CPY, ca, 8'h00, cd};
          OP_AND: micro = {en_w, U_AND, ca, cb, cd};
          OP_OR:  micro = {en_w, U_OR,  ca, cb, cd};
          OP_XOR: micro = {en_w, U_XOR, ca, cb, cd};
          default: micro = 32'h0;
        endcase
      end
      default: micro = 32'h0;
    endcase
  endfunction

  function automatic pos_t advance(input cmd_t c, input pos_t p);
    advance = p;
    case (p.ph)
      PH_PRE: begin
        advance.ph   = PH_BIT;
        advance.idx  = '0;
        advance.half = 1'b0;
      end
      PH_BIT: begin
        if (c.op == OP_SUB && !p.half) begin
          advance.half = 1'b1;
        end else if (p.idx == c.width - WW'(1)) begin
          advance.ph = (c.cout && (c.op == OP_ADD || c.op == OP_SUB)) ? PH_STC : PH_END;
        end else begin
          advance.idx  = p.idx + WW'(1);
          advance.half = 1'b0;
        end
      end
      default: advance.ph = PH_END;
    endcase
  endfunction

  state_t      state_q, state_n;
  cmd_t        cmd_q, cmd_n, cmd_in;
  pos_t        pos_q, pos_n, start_pos;
  logic        pre_q, pre_n;
  logic [31:0] inst_n;
  logic        gnt_n, busy_n, done_n, err_n, bad_cmd;

  assign cmd_in      = {cmd_op_i, cmd_width_i, cmd_a_i, cmd_b_i, cmd_d_i, cmd_tag_i, cmd_cout_i};
  assign bad_cmd     = (cmd_in.op > OP_XOR) || (cmd_in.width == '0) ||
                       (cmd_in.width > WW'(MAX_WIDTH));
  assign cmd_ready_o = (state_q == S_IDLE) && !mem_req_i;

  always_comb begin
    start_pos.ph   = (cmd_in.op == OP_ADD || cmd_in.op == OP_SUB) ? PH_PRE : PH_BIT;
    start_pos.idx  = '0;
    start_pos.half = 1'b0;
  end

  always_comb begin
    state_n = state_q;
    cmd_n   = cmd_q;
    pos_n   = pos_q;
    pre_n   = pre_q;
    inst_n  = 32'h0;
    gnt_n   = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          state_n = S_HOST;
          gnt_n   = 1'b1;
        end else if (cmd_valid_i) begin
          if (bad_cmd) begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end else begin
            cmd_n   = cmd_in;
            inst_n  = micro(cmd_in, start_pos);
            pos_n   = advance(cmd_in, start_pos);
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (pos_q.ph == PH_END) begin
          state_n = S_DRAIN;
        end else if (mem_req_i) begin
          state_n = S_DRAIN;
          pre_n   = 1'b1;
        end else begin
          inst_n = micro(cmd_q, pos_q);
          pos_n  = advance(cmd_q, pos_q);
        end
      end
      S_DRAIN: begin
        if (pre_q) begin
          state_n = S_HOST;
          gnt_n   = mem_req_i;
        end else begin
          done_n  = 1'b1;
          state_n = mem_req_i ? S_HOST : S_IDLE;
          gnt_n   = mem_req_i;
        end
      end
      S_HOST: begin
        if (mem_req_i) begin
          gnt_n = 1'b1;
        end else if (pre_q) begin
          // Carry/tag live in the array, so resuming mid-chain is safe.
          state_n = S_ISSUE;
          pre_n   = 1'b0;
          inst_n  = micro(cmd_q, pos_q);
          pos_n   = advance(cmd_q, pos_q);
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_ISSUE) || (state_n == S_DRAIN) || (state_n == S_HOST && pre_n);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      pos_q     <= '0;
      pre_q     <= 1'b0;
      inst_o    <= 32'h0;
      mem_gnt_o <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state_q   <= state_n;
      cmd_q     <= cmd_n;
      pos_q     <= pos_n;
      pre_q     <= pre_n;
      inst_o    <= inst_n;
      mem_gnt_o <= gnt_n;
      busy_o    <= busy_n;
      done_o    <= done_n;
      err_o     <= err_n;
    end
  end

endmodule

// File: tb/tb_cram_seq.sv
// Scoreboard bench for cram_seq: expected micro-ops and done/err events are queued
// by the stimulus; a monitor pops them and executes micro-ops on a small array model.
module tb_cram_seq;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [5:0]  cmd_width = '0;
  logic [7:0]  ca = '0, cb = '0, cd = '0;
  logic        ctag = 1'b0, ccout = 1'b0;
  logic [31:0] inst;
  logic        mem_req = 1'b0, gnt, busy, done, err;

  int checks = 0, errors = 0, cyc = 0, last_cyc = 0;
  logic [31:0] inst_q[$];
  logic        done_q[$];
  logic [7:0]  arr[256];
  logic [7:0]  car = '0, tgr = '0;

  always #5 clk = ~clk;

  cram_seq dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_width_i(cmd_width), .cmd_a_i(ca), .cmd_b_i(cb), .cmd_d_i(cd),
    .cmd_tag_i(ctag), .cmd_cout_i(ccout), .inst_o(inst), .mem_req_i(mem_req),
    .mem_gnt_o(gnt), .busy_o(busy), .done_o(done), .err_o(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Array model: 8 rows, one byte per column holds that column's bit for every row.
  task automatic exec(input logic [31:0] w);
    logic [7:0] va, vb, res, wm;
    logic wr;
    va  = arr[w[23:16]];
    vb  = arr[w[15:8]];
    wm  = w[28] ? tgr : 8'hFF;
    wr  = 1'b1;
    res = '0;
    case (w[27:24])
      4'hE: begin car = 8'h00; wr = 1'b0; end
      4'hD: begin car = 8'hFF; wr = 1'b0; end
      4'h6: begin res = va ^ vb ^ car; car = (va & vb) | (va & car) | (vb & car); end
      4'h8: res = ~va;
      4'hB: res = car;
      4'h1: res = va;
      4'h2: res = va & vb;
      4'h3: res = va | vb;
      4'h4: res = va ^ vb;
      default: wr = 1'b0;
    endcase
    if (wr) arr[w[7:0]] = (res & wm) | (arr[w[7:0]] & ~wm);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (inst !== 32'h0) begin
        if (inst_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_inst: got %08h want none", inst);
        end else chk("inst", inst, inst_q.pop_front());
        last_cyc = cyc;
        exec(inst);
      end
      if (gnt) chk("gnt_with_nop", inst, 32'h0);
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got err=%0b want no done", err);
        end else begin
          chk("done_err", 32'(err), 32'(done_q.pop_front()));
          if (!err) chk("done_gap", 32'(cyc - last_cyc), 32'd2);
        end
      end
    end
  end

  task automatic load(input int col, input int w, input int r, input logic [31:0] v);
    for (int i = 0; i < w; i++) arr[(col + i) % 256][r] = v[i];
  endtask

  function automatic logic [31:0] getv(input int col, input int w, input int r);
    getv = '0;
    for (int i = 0; i < w; i++) getv[i] = arr[(col + i) % 256][r];
  endfunction

  task automatic drive(input logic [2:0] op, input int w, input logic [7:0] a, b, d,
                       input logic tag, cout);
    cmd_op = op; cmd_width = 6'(w); ca = a; cb = b; cd = d; ctag = tag; ccout = cout;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    #1;
    cmd_valid = 1'b0;
    cmd_op = 3'd6; cmd_width = 6'd63; ca = 8'hEE; cb = 8'hEE; cd = 8'hEE;
    ctag = 1'b1; ccout = 1'b1;
    if (!ok) fail_now("accept");
  endtask

  task automatic send(input logic [2:0] op, input int w, input logic [7:0] a, b, d,
                      input logic tag, cout);
    @(negedge clk);
    drive(op, w, a, b, d, tag, cout);
    wait_accept();
  endtask

  task automatic settle();
    bit ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (inst_q.size() == 0 && done_q.size() == 0 && !busy && !done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("settle");
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] av, bv;
    for (int i = 0; i < 256; i++) arr[i] = 8'h00;
    #12;
    chk("rst_inst", inst, 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk) rst = 1'b0;

    // ADD W=4 with carry-out column
    for (int r = 0; r < 8; r++) begin
      load(0, 4, r, 32'((r * 5 + 3) & 15));
      load(8, 4, r, 32'((r * 7 + 1) & 15));
    end
    inst_q = '{32'h8E000000, 32'h86000810, 32'h86010911, 32'h86020A12, 32'h86030B13, 32'h8B000014};
    done_q.push_back(1'b0);
    send(3'd0, 4, 8'd0, 8'd8, 8'd16, 1'b0, 1'b1);
    settle();
    for (int r = 0; r < 8; r++)
      chk("add4_sum", getv(16, 5, r), 32'(((r * 5 + 3) & 15) + ((r * 7 + 1) & 15)));

    // SUB W=2 tag-masked: untagged rows keep columns 3/4
    tgr = 8'h55; arr[1] = 8'h96; arr[2] = 8'h5A; arr[3] = 8'h3C; arr[4] = 8'hC3;
    inst_q = '{32'h8D000000, 32'h980200FF, 32'h9601FF03, 32'h980300FF, 32'h9602FF04};
    done_q.push_back(1'b0);
    send(3'd1, 2, 8'd1, 8'd2, 8'd3, 1'b1, 1'b0);
    settle();
    chk("sub_untag_c3", 32'(arr[3] & 8'hAA), 32'(8'h3C & 8'hAA));
    chk("sub_untag_c4", 32'(arr[4] & 8'hAA), 32'(8'hC3 & 8'hAA));

    // SUB W=4 untagged with carry-out: result = A + 16 - B in 5 bits
    for (int r = 0; r < 8; r++) begin
      load(10, 4, r, 32'((r * 3 + 9) & 15));
      load(20, 4, r, 32'((r * 5 + 2) & 15));
    end
    inst_q = '{32'h8D000000, 32'h881400FF, 32'h860AFF1E, 32'h881500FF, 32'h860BFF1F,
               32'h881600FF, 32'h860CFF20, 32'h881700FF, 32'h860DFF21, 32'h8B000022};
    done_q.push_back(1'b0);
    send(3'd1, 4, 8'd10, 8'd20, 8'd30, 1'b0, 1'b1);
    settle();
    for (int r = 0; r < 8; r++)
      chk("sub4_diff", getv(30, 5, r), 32'(((r * 3 + 9) & 15) + 16 - ((r * 5 + 2) & 15)));

    // ADD W=8 preempted by the host at the 3rd ADD
    for (int r = 0; r < 8; r++) begin
      load(32'h20, 8, r, 32'((r * 37 + 11) & 255));
      load(32'h30, 8, r, 32'((r * 91 + 200) & 255));
    end
    inst_q.push_back(32'h8E000000);
    for (int i = 0; i < 8; i++)
      inst_q.push_back({8'h86, 8'(32'h20 + i), 8'(32'h30 + i), 8'(32'h40 + i)});
    done_q.push_back(1'b0);
    send(3'd0, 8, 8'h20, 8'h30, 8'h40, 1'b0, 1'b0);
    begin
      bit seen = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk); #1;
        if (inst == 32'h86223242) begin seen = 1; break; end
      end
      if (!seen) fail_now("pre_third_add");
    end
    mem_req = 1'b1;
    @(negedge clk); #1;
    chk("pre_nop", inst, 32'h0);
    chk("pre_gnt_late", 32'(gnt), 32'd0);
    @(negedge clk); #1;
    chk("pre_gnt", 32'(gnt), 32'd1);
    chk("pre_busy", 32'(busy), 32'd1);
    chk("pre_ready", 32'(cmd_ready), 32'd0);
    arr[100] = 8'h5A;
    @(negedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk); #1;
    chk("pre_release", 32'(gnt), 32'd0);
    settle();
    chk("host_word", 32'(arr[100]), 32'h5A);
    for (int r = 0; r < 8; r++) begin
      av = 32'((r * 37 + 11) & 255);
      bv = 32'((r * 91 + 200) & 255);
      chk("add8_sum", getv(32'h40, 8, r), (av + bv) & 32'hFF);
    end

    // Command and host request in the same IDLE cycle: host wins
    @(negedge clk);
    drive(3'd2, 3, 8'hFE, 8'h00, 8'hC8, 1'b0, 1'b0);
    mem_req = 1'b1;
    #1 chk("req_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk); #1;
    chk("req_gnt", 32'(gnt), 32'd1);
    chk("req_busy", 32'(busy), 32'd0);
    mem_req = 1'b0;
    inst_q = '{32'h81FE00C8, 32'h81FF00C9, 32'h810000CA};
    done_q.push_back(1'b0);
    wait_accept();
    settle();

    // Logic ops
    inst_q = '{32'h92010203}; done_q.push_back(1'b0);
    send(3'd3, 1, 8'd1, 8'd2, 8'd3, 1'b1, 1'b0); settle();
    inst_q = '{32'h83040608, 32'h83050709}; done_q.push_back(1'b0);
    send(3'd4, 2, 8'd4, 8'd6, 8'd8, 1'b0, 1'b1); settle();
    inst_q = '{32'h8407090B}; done_q.push_back(1'b0);
    send(3'd5, 1, 8'd7, 8'd9, 8'd11, 1'b0, 1'b0); settle();

    // Widest legal operand
    for (int i = 0; i < 32; i++) inst_q.push_back({8'h81, 8'(i), 8'h00, 8'(100 + i)});
    done_q.push_back(1'b0);
    send(3'd2, 32, 8'd0, 8'd0, 8'd100, 1'b0, 1'b0);
    settle();

    // Rejected commands: W=0, illegal op, W>MAX_WIDTH
    for (int k = 0; k < 3; k++) begin
      done_q.push_back(1'b1);
      case (k)
        0: send(3'd0, 0, 8'd0, 8'd8, 8'd16, 1'b0, 1'b0);
        1: send(3'd7, 4, 8'd0, 8'd8, 8'd16, 1'b0, 1'b0);
        default: send(3'd0, 33, 8'd0, 8'd8, 8'd16, 1'b0, 1'b0);
      endcase
      @(negedge clk); #1;
      chk("rej_done", 32'(done), 32'd1);
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_busy", 32'(busy), 32'd0);
      settle();
    end

    // Reset in the middle of a SUB
    inst_q = '{32'h8D000000, 32'h881400FF, 32'h860AFF1E, 32'h881500FF, 32'h860BFF1F,
               32'h881600FF, 32'h860CFF20, 32'h881700FF, 32'h860DFF21, 32'h8B000022};
    done_q.push_back(1'b0);
    send(3'd1, 4, 8'd10, 8'd20, 8'd30, 1'b0, 1'b1);
    begin
      bit seen = 0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk); #1;
        if (inst_q.size() <= 7) begin seen = 1; break; end
      end
      if (!seen) fail_now("mid_sub");
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_inst", inst, 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    inst_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    inst_q = '{32'h8E000000, 32'h86000102};
    done_q.push_back(1'b0);
    send(3'd0, 1, 8'd0, 8'd1, 8'd2, 1'b0, 1'b0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
